// File: rtl/divisor_iterativo.sv
// rtl/divisor_iterativo.sv - sequential restoring divider, one quotient bit per clock
//
// Purpose:
//   Multi-cycle divider with an init/busy/done handshake. Operands are captured
//   on the accepted init edge, the unsigned core runs for WIDTH cycles on the
//   operand magnitudes and the signed results are registered when entering DONE.
//   Divide-by-zero skips the core entirely.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   init      start request, only honoured in IDLE
//   A, B      dividend / divisor, captured on the accepted init edge
//   busy      high while the core iterates (state CALC)
//   done      one-cycle pulse when results become valid
//   cociente  quotient, held until the next DONE entry
//   residuo   remainder, held until the next DONE entry
//   div_cero  last accepted operation had B == 0
//   desborde  signed overflow (-2^(WIDTH-1) / -1); always 0 when SIGNED = 0

module divisor_iterativo #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] residuo,
  output logic             div_cero,
  output logic             desborde
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;   // quotient must be negated at the end
  logic             neg_r_q, neg_r_d;   // remainder must be negated at the end
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] cociente_q, cociente_d;
  logic [WIDTH-1:0] residuo_q, residuo_d;
  logic             div_cero_q, div_cero_d;
  logic             desborde_q, desborde_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH-1:0] q_final, r_final;

  always_comb begin
    // Magnitudes: -2^(WIDTH-1) maps onto itself, which reads correctly as an
    // unsigned magnitude, so the overflow case needs no special datapath.
    a_neg = SIGNED & A[WIDTH-1];
    b_neg = SIGNED & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;

    // One restoring step. The trial value is WIDTH+1 bits wide so the bit
    // shifted out of the remainder takes part in the comparison.
    shifted  = {rem_q, quo_q[WIDTH-1]};
    fits     = shifted >= {1'b0, dvs_q};
    rem_step = fits ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], fits};
    q_final  = neg_q_q ? -quo_step : quo_step;
    r_final  = neg_r_q ? -rem_step : rem_step;

    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cociente_d = cociente_q;
    residuo_d  = residuo_q;
    div_cero_d = div_cero_q;
    desborde_d = desborde_q;

    case (state_q)
      IDLE: begin
        if (init) begin
          neg_q_d = a_neg ^ b_neg;
          neg_r_d = a_neg;
          ovf_d   = SIGNED & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (&B);
          if (B == '0) begin
            state_d    = DONE;
            done_d     = 1'b1;
            cociente_d = '1;
            residuo_d  = A;
            div_cero_d = 1'b1;
            desborde_d = 1'b0;
          end else begin
            state_d = CALC;
            busy_d  = 1'b1;
            count_d = CW'(WIDTH);
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
          end
        end
      end
      CALC: begin
        rem_d   = rem_step;
        quo_d   = quo_step;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          cociente_d = q_final;
          residuo_d  = r_final;
          div_cero_d = 1'b0;
          desborde_d = ovf_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cociente_q <= '0;
      residuo_q  <= '0;
      div_cero_q <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cociente_q <= cociente_d;
      residuo_q  <= residuo_d;
      div_cero_q <= div_cero_d;
      desborde_q <= desborde_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cociente = cociente_q;
  assign residuo  = residuo_q;
  assign div_cero = div_cero_q;
  assign desborde = desborde_q;

endmodule
